seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
- Receiving end of the 4-digit multiplexed 7-segment interface.
- Watches the active-low anode and cathode lines produced by the board display driver and reconstructs the four displayed hex/BCD digits.
- Flags invalid patterns, illegal anode codes and a blanked display.
- Used as an on-chip self-check and as a bench monitor for display-driving blocks.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured. Legal range is at least 2.
- OFF_TIMEOUT, 1024: consecutive all-anodes-off cycles before the display is declared off.
- CNT_W, 11: width of the stability and timeout counters. Must hold OFF_TIMEOUT.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- anodes, in, 4: digit enables, active low. 4'hE = digit0, 4'hD = digit1, 4'hB = digit2, 4'h7 = digit3.
- segs, in, 7: cathodes, active low, {G,F,E,D,C,B,A}; bit0 = A.
- bcd0, out, 4: last captured value of digit0.
- bcd1, out, 4: last captured value of digit1.
- bcd2, out, 4: last captured value of digit2.
- bcd3, out, 4: last captured value of digit3.
- digit_vld, out, 4: bit i set once digit i has been captured in the current frame.
- digit_err, out, 4: bit i set if the last capture of digit i was an undecodable pattern.
- frame_vld, out, 1: one-cycle pulse when all four digits have been captured.
- anode_err, out, 1: sticky. Set when more than one anode is low for STABLE_CYCLES samples.
- disp_off, out, 1: high while the display is considered disabled.

Behaviour:
- Reset (async, rst_n=0):
  - bcd0..3 = 0, digit_vld = 0, digit_err = 0.
  - frame_vld = 0, anode_err = 0, disp_off = 1.
  - FSM = OFF, counters = 0.
- Input register: anodes and segs are registered once into a_q and s_q. The previous sample is held as a_p and s_p.
- Stability counter stab:
  - Reset to 0 whenever {a_q,s_q} != {a_p,s_p}; otherwise it increments and saturates at STABLE_CYCLES.
  - A capture event fires on the single cycle stab transitions to STABLE_CYCLES-1.
  - Capture latency: outputs update on the edge STABLE_CYCLES+1 clocks after the pins settle.
- Decode (combinational on s_q):
  - Standard hex patterns 0-F map to their value, e.g. active-low 7'b1000000 -> 0 and 7'b0010000 -> 9.
  - Any other pattern, including blank 7'h7F, gives err=1 with value 4'h0.
- FSM states OFF, SCAN, HOLD:
  - OFF: disp_off=1. The first capture event with a one-hot-low anode code moves to SCAN and sets disp_off=0.
  - SCAN: on a capture event with a legal anode code k, bcdk <= value, digit_err[k] <= err, digit_vld[k] <= 1, then go to HOLD.
  - HOLD: wait until the registered sample changes (stab=0), then return to SCAN. Each displayed digit window therefore gives at most one capture.
  - Frame completion: when digit_vld would become 4'hF, frame_vld pulses for 1 cycle and digit_vld clears to 0 on the same edge. Bits for that frame are lost.
  - Recapture of an already-valid digit within a frame overwrites bcdk and digit_err[k]. It does not advance the frame.
- Illegal anode code (zero or two+ lows, other than 4'hF):
  - A capture event sets anode_err (sticky until reset). No digit is written.
- All-off (a_q == 4'hF):
  - An off counter increments each cycle; any other code clears it.
  - When it reaches OFF_TIMEOUT-1: disp_off <= 1, digit_vld <= 0, FSM -> OFF. bcd registers keep their values.
- Reset asserted mid-frame aborts immediately to reset values. No frame_vld is issued.

Optional Feature:
- Macro: SEG7_SCAN_CAPTURE_DP_EN.
- Defined:
  - Adds input dp (1 bit, active low) and output dp_out (4 bits).
  - dp is registered alongside segs and is part of the stability compare.
  - dp_out[k] <= ~dp_q on capture of digit k. Reset value 0.
- Undefined: neither port exists; decimal points are ignored.

Decomposition:
- seg7_pkg holds:
  - the anode codes DIG0..DIG3 (4'hE/D/B/7) and ANODES_OFF = 4'hF;
  - the 16 active-low segment pattern constants;
  - the FSM state enum {OFF, SCAN, HOLD}.
- One sub-module, seg7_pattern_decode: combinational s -> {err, value[3:0]}. It is reused by other monitors.

Test Plan:
- Reset then drive the sequence anodes E/D/B/7 with patterns 1,2,3,4, 20 clocks each. Required: bcd0..3 = 1,2,3,4; one frame_vld pulse; digit_vld returns to 0.
- Glitch: hold anodes=E with segs toggling every 2 clocks, STABLE_CYCLES=4. Required: no capture and digit_vld stays 0. Then hold segs=7'b1000000 for 6 clocks. Required: bcd0=0 and digit_vld=4'b0001, latency exactly 5 clocks.
- segs=7'h7F on anodes=B for 10 clocks. Required: digit_err=4'b0100, bcd2=0.
- anodes=4'hC for 10 clocks. Required: anode_err=1 and stays 1 after later valid frames.
- After one frame, anodes=F for 1024 clocks. Required: disp_off rises exactly at the timeout, digit_vld=0, bcd values retained. Next legal digit clears disp_off.
- Assert rst_n=0 after 2 digits are captured. Required: all outputs return to reset values asynchronously and no frame_vld pulse occurs.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan monitors.
//   - Anode codes (active low) for the four digit positions and the all-off code.
//   - Active-low segment patterns {G,F,E,D,C,B,A} for hex digits 0-F.
//   - Capture FSM state type.
package seg7_pkg;

  localparam logic [3:0] DIG0       = 4'hE;
  localparam logic [3:0] DIG1       = 4'hD;
  localparam logic [3:0] DIG2       = 4'hB;
  localparam logic [3:0] DIG3       = 4'h7;
  localparam logic [3:0] ANODES_OFF = 4'hF;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  typedef enum logic [1:0] {
    StOff,
    StScan,
    StHold
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low 7-segment pattern decoder.
//   s     : segment pattern {G,F,E,D,C,B,A}, active low
//   err   : 1 when s is not one of the 16 hex glyphs (blank included)
//   value : decoded hex value, 4'h0 when err is set
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] s,
  output logic       err,
  output logic [3:0] value
);

  always_comb begin
    err   = 1'b0;
    value = 4'h0;
    case (s)
      SEG_0:   value = 4'h0;
      SEG_1:   value = 4'h1;
      SEG_2:   value = 4'h2;
      SEG_3:   value = 4'h3;
      SEG_4:   value = 4'h4;
      SEG_5:   value = 4'h5;
      SEG_6:   value = 4'h6;
      SEG_7:   value = 4'h7;
      SEG_8:   value = 4'h8;
      SEG_9:   value = 4'h9;
      SEG_A:   value = 4'hA;
      SEG_B:   value = 4'hB;
      SEG_C:   value = 4'hC;
      SEG_D:   value = 4'hD;
      SEG_E:   value = 4'hE;
      SEG_F:   value = 4'hF;
      default: err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receiving end of a 4-digit multiplexed 7-segment display. Samples the
// active-low anode/cathode lines, waits for them to be stable, and rebuilds
// the four displayed digits.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   anodes[3:0]         : digit enables, active low (E/D/B/7 = digit 0..3)
//   segs[6:0]           : cathodes, active low, {G,F,E,D,C,B,A}
//   bcd0..bcd3[3:0]     : last captured value per digit
//   digit_vld[3:0]      : digit captured in the current frame
//   digit_err[3:0]      : last capture of the digit was undecodable
//   frame_vld           : one-cycle pulse when all four digits were captured
//   anode_err           : sticky, a stable illegal anode code was seen
//   disp_off            : display considered disabled
// Optional (macro SEG7_SCAN_CAPTURE_DP_EN):
//   dp                  : decimal point, active low, part of the stability compare
//   dp_out[3:0]         : decimal point state captured per digit
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned OFF_TIMEOUT   = 1024,
  parameter int unsigned CNT_W         = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] anodes,
  input  logic [6:0] segs,
`ifdef SEG7_SCAN_CAPTURE_DP_EN
  input  logic       dp,
  output logic [3:0] dp_out,
`endif
  output logic [3:0] bcd0,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic [3:0] digit_vld,
  output logic [3:0] digit_err,
  output logic       frame_vld,
  output logic       anode_err,
  output logic       disp_off
);

  localparam logic [CNT_W-1:0] StabMax = CNT_W'(STABLE_CYCLES);
  // Capture fires on the cycle stab moves from STABLE_CYCLES-2 to STABLE_CYCLES-1.
  localparam logic [CNT_W-1:0] StabCap = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] OffLast = CNT_W'(OFF_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OffFire = CNT_W'(OFF_TIMEOUT - 2);

  // Input sample and previous sample
  logic [3:0] a_q, a_p;
  logic [6:0] s_q, s_p;
  logic       same;

`ifdef SEG7_SCAN_CAPTURE_DP_EN
  logic dp_q, dp_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_q <= 1'b1;
      dp_p <= 1'b1;
    end else begin
      dp_q <= dp;
      dp_p <= dp_q;
    end
  end

  assign same = (a_q == a_p) && (s_q == s_p) && (dp_q == dp_p);
`else
  assign same = (a_q == a_p) && (s_q == s_p);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= ANODES_OFF;
      a_p <= ANODES_OFF;
      s_q <= 7'h7F;
      s_p <= 7'h7F;
    end else begin
      a_q <= anodes;
      a_p <= a_q;
      s_q <= segs;
      s_p <= s_q;
    end
  end

  // Stability counter
  logic [CNT_W-1:0] stab_q, stab_d;
  logic             cap;

  always_comb begin
    stab_d = stab_q;
    if (!same) begin
      stab_d = '0;
    end else if (stab_q != StabMax) begin
      stab_d = stab_q + 1'b1;
    end
  end

  assign cap = same && (stab_q == StabCap);

  // Anode decode
  logic       dig_legal;
  logic [1:0] dig_idx;
  logic [3:0] dig_oh;
  logic       all_off;
  logic       anode_bad;

  always_comb begin
    dig_legal = 1'b1;
    dig_idx   = 2'd0;
    case (a_q)
      DIG0:    dig_idx = 2'd0;
      DIG1:    dig_idx = 2'd1;
      DIG2:    dig_idx = 2'd2;
      DIG3:    dig_idx = 2'd3;
      default: dig_legal = 1'b0;
    endcase
  end

  assign dig_oh    = 4'b0001 << dig_idx;
  assign all_off   = (a_q == ANODES_OFF);
  assign anode_bad = !dig_legal && !all_off;

  // All-off timeout counter; saturates so the timeout fires once per off period
  logic [CNT_W-1:0] off_q, off_d;
  logic             timeout;

  always_comb begin
    off_d = off_q;
    if (!all_off) begin
      off_d = '0;
    end else if (off_q != OffLast) begin
      off_d = off_q + 1'b1;
    end
  end

  assign timeout = all_off && (off_q == OffFire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_q <= '0;
      off_q  <= '0;
    end else begin
      stab_q <= stab_d;
      off_q  <= off_d;
    end
  end

  // Pattern decode of the current sample
  logic       dec_err;
  logic [3:0] dec_val;

  seg7_pattern_decode u_decode (
    .s     (s_q),
    .err   (dec_err),
    .value (dec_val)
  );

  // Capture FSM with registered outputs
  state_e     state_q;
  logic [3:0] bcd_q [4];
  logic [3:0] vld_next;

  assign vld_next = digit_vld | dig_oh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StOff;
      for (int i = 0; i < 4; i++) bcd_q[i] <= 4'h0;
      digit_vld <= 4'h0;
      digit_err <= 4'h0;
      frame_vld <= 1'b0;
      anode_err <= 1'b0;
      disp_off  <= 1'b1;
`ifdef SEG7_SCAN_CAPTURE_DP_EN
      dp_out    <= 4'h0;
`endif
    end else begin
      frame_vld <= 1'b0;
      if (cap && anode_bad) begin
        anode_err <= 1'b1;
      end
      if (timeout) begin
        // bcd registers deliberately keep their values
        disp_off  <= 1'b1;
        digit_vld <= 4'h0;
        state_q   <= StOff;
      end else begin
        unique case (state_q)
          // A legal capture in OFF both wakes the display and records the digit,
          // so the first digit after power-up counts towards the frame.
          StOff, StScan: begin
            if (cap && dig_legal) begin
              bcd_q[dig_idx]     <= dec_val;
              digit_err[dig_idx] <= dec_err;
`ifdef SEG7_SCAN_CAPTURE_DP_EN
              dp_out[dig_idx]    <= ~dp_q;
`endif
              if (vld_next == 4'hF) begin
                frame_vld <= 1'b1;
                digit_vld <= 4'h0;
              end else begin
                digit_vld <= vld_next;
              end
              disp_off <= 1'b0;
              state_q  <= StHold;
            end
          end
          StHold: begin
            if (!same) begin
              state_q <= StScan;
            end
          end
          default: state_q <= StOff;
        endcase
      end
    end
  end

  assign bcd0 = bcd_q[0];
  assign bcd1 = bcd_q[1];
  assign bcd2 = bcd_q[2];
  assign bcd3 = bcd_q[3];

endmodule

// File: tb/tb_seg7_scan_capture.sv
module tb_seg7_scan_capture;

  logic       clk;
  logic       rst_n;
  logic [3:0] anodes;
  logic [6:0] segs;
  logic [3:0] bcd0, bcd1, bcd2, bcd3;
  logic [3:0] digit_vld, digit_err;
  logic       frame_vld, anode_err, disp_off;
`ifdef SEG7_SCAN_CAPTURE_DP_EN
  logic [3:0] dp_out;
`endif

  seg7_scan_capture #(
    .STABLE_CYCLES (4),
    .OFF_TIMEOUT   (1024),
    .CNT_W         (11)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .anodes    (anodes),
    .segs      (segs),
`ifdef SEG7_SCAN_CAPTURE_DP_EN
    .dp        (1'b1),
    .dp_out    (dp_out),
`endif
    .bcd0      (bcd0),
    .bcd1      (bcd1),
    .bcd2      (bcd2),
    .bcd3      (bcd3),
    .digit_vld (digit_vld),
    .digit_err (digit_err),
    .frame_vld (frame_vld),
    .anode_err (anode_err),
    .disp_off  (disp_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int frames   = 0;

  typedef struct {
    int         idx;
    logic [3:0] val;
    logic       err;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [3:0] an;
    logic [6:0] sg;
    int         n;
    bit         push;
    logic [3:0] exp_vld;
    logic [3:0] exp_err;
    logic [3:0] exp_bcd;
    logic       exp_aerr;
  } vec_t;
  vec_t tbl[10];

  logic [6:0] pat[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int an2idx(input logic [3:0] an);
    case (an)
      4'hE:    return 0;
      4'hD:    return 1;
      4'hB:    return 2;
      4'h7:    return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [3:0] bcd_of(input int i);
    case (i)
      0:       return bcd0;
      1:       return bcd1;
      2:       return bcd2;
      default: return bcd3;
    endcase
  endfunction

  // Hold pins at a value for n clocks, then sit just after the last edge.
  task automatic drive(input logic [3:0] an, input logic [6:0] sg, input int n,
                       input bit push, input logic [3:0] val, input logic err);
    @(negedge clk);
    anodes = an;
    segs   = sg;
    if (push) sb_q.push_back('{an2idx(an), val, err});
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every newly-valid digit bit pops one expected capture.
  logic [3:0] prev_vld = 4'h0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      begin
        logic [3:0] newb;
        sb_t        e;
        newb = frame_vld ? ~prev_vld : (digit_vld & ~prev_vld);
        if (frame_vld) frames++;
        if (newb != 4'h0) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(newb), 32'h0);
          end else begin
            e = sb_q.pop_front();
            check("sb_digit", 32'(newb), 32'(4'b0001 << e.idx));
            check("sb_bcd", 32'(bcd_of(e.idx)), 32'(e.val));
            check("sb_err", 32'(digit_err[e.idx]), 32'(e.err));
          end
        end
        prev_vld = digit_vld;
      end
    end
  end

  initial begin
    pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    tbl[0] = '{4'hE, pat[1],  20, 1'b1, 4'b0001, 4'b0000, 4'h1, 1'b0};
    tbl[1] = '{4'hD, pat[2],  20, 1'b1, 4'b0011, 4'b0000, 4'h2, 1'b0};
    tbl[2] = '{4'hB, pat[3],  20, 1'b1, 4'b0111, 4'b0000, 4'h3, 1'b0};
    tbl[3] = '{4'h7, pat[4],  20, 1'b1, 4'b0000, 4'b0000, 4'h4, 1'b0};
    tbl[4] = '{4'hC, pat[1],  10, 1'b0, 4'b0000, 4'b0000, 4'h0, 1'b1};
    tbl[5] = '{4'hE, pat[9],  20, 1'b1, 4'b0001, 4'b0000, 4'h9, 1'b1};
    tbl[6] = '{4'hE, pat[10], 20, 1'b0, 4'b0001, 4'b0000, 4'hA, 1'b1};
    tbl[7] = '{4'hB, 7'h7F,   10, 1'b1, 4'b0101, 4'b0100, 4'h0, 1'b1};
    tbl[8] = '{4'h7, pat[15], 10, 1'b1, 4'b1101, 4'b0100, 4'hF, 1'b1};
    tbl[9] = '{4'hD, pat[5],  10, 1'b1, 4'b0000, 4'b0100, 4'h5, 1'b1};

    anodes = 4'hF;
    segs   = 7'h7F;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd", 32'({bcd3, bcd2, bcd1, bcd0}), 32'h0);
    check("rst_vld", 32'(digit_vld), 32'h0);
    check("rst_err", 32'(digit_err), 32'h0);
    check("rst_frame", 32'(frame_vld), 32'h0);
    check("rst_aerr", 32'(anode_err), 32'h0);
    check("rst_off", 32'(disp_off), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      int k;
      k = an2idx(tbl[i].an);
      drive(tbl[i].an, tbl[i].sg, tbl[i].n, tbl[i].push, tbl[i].exp_bcd, tbl[i].exp_err[k < 0 ? 0 : k]);
      check($sformatf("v%0d_vld", i), 32'(digit_vld), 32'(tbl[i].exp_vld));
      check($sformatf("v%0d_err", i), 32'(digit_err), 32'(tbl[i].exp_err));
      check($sformatf("v%0d_aerr", i), 32'(anode_err), 32'(tbl[i].exp_aerr));
      check($sformatf("v%0d_off", i), 32'(disp_off), 32'h0);
      if (k >= 0) check($sformatf("v%0d_bcd", i), 32'(bcd_of(k)), 32'(tbl[i].exp_bcd));
      if (i == 3) begin
        check("frame1_bcd", 32'({bcd3, bcd2, bcd1, bcd0}), 32'h4321);
        check("frame1_cnt", frames, 1);
      end
    end
    check("frame2_cnt", frames, 2);
    check("frame2_pulse_end", 32'(frame_vld), 32'h0);

    // Glitching segments must never capture
    for (int i = 0; i < 8; i++) begin
      drive(4'hE, (i % 2) ? pat[2] : pat[1], 2, 1'b0, 4'h0, 1'b0);
      check("glitch_vld", 32'(digit_vld), 32'h0);
    end
    drive(4'hE, pat[0], 4, 1'b1, 4'h0, 1'b0);
    check("lat_before5", 32'(digit_vld), 32'h0);
    @(posedge clk);
    #1;
    check("lat_at5_vld", 32'(digit_vld), 32'h1);
    check("lat_at5_bcd", 32'(bcd0), 32'h0);
    @(posedge clk);
    #1;

    // Frame 3 (digit0 recaptured), then one more digit before the display goes off
    drive(4'hE, pat[6], 10, 1'b0, 4'h0, 1'b0);
    drive(4'hD, pat[7], 10, 1'b1, 4'h7, 1'b0);
    drive(4'hB, pat[8], 10, 1'b1, 4'h8, 1'b0);
    drive(4'h7, pat[9], 10, 1'b1, 4'h9, 1'b0);
    check("frame3_cnt", frames, 3);
    drive(4'hE, pat[3], 10, 1'b1, 4'h3, 1'b0);
    check("pre_off_vld", 32'(digit_vld), 32'h1);

    drive(4'hF, 7'h7F, 1023, 1'b0, 4'h0, 1'b0);
    check("off_before", 32'(disp_off), 32'h0);
    check("off_before_vld", 32'(digit_vld), 32'h1);
    @(posedge clk);
    #1;
    check("off_at", 32'(disp_off), 32'h1);
    check("off_vld", 32'(digit_vld), 32'h0);
    check("off_bcd_kept", 32'({bcd3, bcd2, bcd1, bcd0}), 32'h9873);

    drive(4'hD, pat[1], 10, 1'b1, 4'h1, 1'b0);
    check("wake_off", 32'(disp_off), 32'h0);
    check("wake_vld", 32'(digit_vld), 32'h2);
    drive(4'hB, pat[2], 10, 1'b1, 4'h2, 1'b0);
    check("mid_vld", 32'(digit_vld), 32'h6);
    check("aerr_sticky", 32'(anode_err), 32'h1);

    // Asynchronous reset mid-frame
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_bcd", 32'({bcd3, bcd2, bcd1, bcd0}), 32'h0);
    check("arst_vld", 32'(digit_vld), 32'h0);
    check("arst_err", 32'(digit_err), 32'h0);
    check("arst_aerr", 32'(anode_err), 32'h0);
    check("arst_off", 32'(disp_off), 32'h1);
    anodes = 4'hF;
    segs   = 7'h7F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("arst_no_frame", frames, 3);
    check("arst_frame_vld", 32'(frame_vld), 32'h0);
    check("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
